mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the pipeline's IF stage (fetch) and MEM stage (load/store).
- Grants one requester at a time, sequences the memory handshake with variable wait states, and returns read data.
- Drives per-stage stall signals to the pipeline control.
- MEM stage has priority, with a bounded-starvation rule for IF and a watchdog timeout on the memory.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the IF (fetch) and MEM
// (load/store) pipeline stages. One requester is granted at a time. MEM has priority, but IF
// is forced through after MAX_MEM_STREAK back-to-back MEM grants made while IF was waiting.
// A watchdog aborts an access after TIMEOUT_CYCLES cycles without m_ready.
//
// Ports:
//   clk, reset                     rising-edge clock, asynchronous active-high reset
//   if_req/if_addr                 fetch request (level) and byte address
//   if_rdata/if_done               fetched word and one-cycle completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be               load/store request (level) and its fields
//   mem_rdata/mem_done             load data and one-cycle completion pulse
//   bus_err                        pulses with a done when that access timed out
//   stall_if/stall_mem             per-stage stalls: req & ~done
//   m_req/m_we/m_addr/m_wdata/m_be memory command, constant for a whole access
//   m_rdata/m_ready                memory read data and completion, sampled only in ACCESS
module mem_port_arbiter #(
  parameter int unsigned MAX_MEM_STREAK = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_be,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        bus_err,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ready
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  localparam logic [3:0] StreakMax   = 4'(MAX_MEM_STREAK);
  localparam logic [9:0] TimeoutLast = 10'(TIMEOUT_CYCLES - 1);

  state_e     state_q;
  logic [3:0] streak_q;
  logic [9:0] tcnt_q;
  logic       owner_mem_q;  // 1: current access belongs to MEM, 0: to IF

  logic grant_if;
  logic grant_mem;
  logic timeout_hit;

  // IF wins only when alone or when MEM has used up its streak allowance.
  assign grant_if    = if_req & (~mem_req | (streak_q == StreakMax));
  assign grant_mem   = mem_req & ~grant_if;
  // tcnt_q counts completed ACCESS cycles; this is the last allowed one.
  assign timeout_hit = (tcnt_q == TimeoutLast);

  assign stall_if  = if_req & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      streak_q    <= 4'd0;
      tcnt_q      <= 10'd0;
      owner_mem_q <= 1'b0;
      if_rdata    <= 32'd0;
      if_done     <= 1'b0;
      mem_rdata   <= 32'd0;
      mem_done    <= 1'b0;
      bus_err     <= 1'b0;
      m_req       <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= 32'd0;
      m_wdata     <= 32'd0;
      m_be        <= 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_mem) begin
            state_q     <= StAccess;
            owner_mem_q <= 1'b1;
            m_req       <= 1'b1;
            m_we        <= mem_we;
            m_addr      <= mem_addr;
            m_wdata     <= mem_wdata;
            m_be        <= mem_be;
            // Only grants that make IF wait count toward the streak.
            if (if_req) begin
              if (streak_q != StreakMax) begin
                streak_q <= streak_q + 4'd1;
              end
            end else begin
              streak_q <= 4'd0;
            end
          end else if (grant_if) begin
            state_q     <= StAccess;
            owner_mem_q <= 1'b0;
            m_req       <= 1'b1;
            m_we        <= 1'b0;
            m_addr      <= if_addr;
            m_wdata     <= 32'd0;
            m_be        <= 4'hF;
            streak_q    <= 4'd0;
          end
        end

        StAccess: begin
          tcnt_q <= tcnt_q + 10'd1;
          // m_ready takes precedence over a timeout landing on the same cycle.
          if (m_ready) begin
            state_q <= StResp;
            m_req   <= 1'b0;
            if (owner_mem_q) begin
              mem_rdata <= m_rdata;
              mem_done  <= 1'b1;
            end else begin
              if_rdata <= m_rdata;
              if_done  <= 1'b1;
            end
          end else if (timeout_hit) begin
            state_q <= StResp;
            m_req   <= 1'b0;
            bus_err <= 1'b1;
            if (owner_mem_q) begin
              mem_rdata <= 32'd0;
              mem_done  <= 1'b1;
            end else begin
              if_rdata <= 32'd0;
              if_done  <= 1'b1;
            end
          end
        end

        StResp: begin
          state_q  <= StIdle;
          if_done  <= 1'b0;
          mem_done <= 1'b0;
          bus_err  <= 1'b0;
          tcnt_q   <= 10'd0;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MAX_MEM_STREAK=4 and TIMEOUT_CYCLES=8.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        bus_err;
  logic        stall_if;
  logic        stall_mem;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;
  logic        m_ready;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .MAX_MEM_STREAK(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be   (mem_be),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .bus_err  (bus_err),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .m_req    (m_req),
    .m_we     (m_we),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_rdata  (m_rdata),
    .m_ready  (m_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Dones and m_req must never overlap.
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      assert (!(if_done && mem_done) && !(m_req && (if_done || mem_done))) else begin
        bad++;
        $error("FAIL exclusive: if_done=%b mem_done=%b m_req=%b expected no overlap",
               if_done, mem_done, m_req);
      end
    end
  end

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = 32'd0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_be = 4'd0;
    m_rdata = 32'd0; m_ready = 1'b0;
    repeat (2) tick();
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);
    reset = 1'b0;

    // 1: zero-wait fetch, then m_ready outside ACCESS is ignored
    tick();
    if_req = 1'b1; if_addr = 32'h10; #1;
    chk("t1_c0_stall_if", {31'd0, stall_if}, 32'd1);
    chk("t1_c0_m_req", {31'd0, m_req}, 32'd0);
    tick();
    m_ready = 1'b1; m_rdata = 32'h0050_0093; #1;
    chk("t1_c1_m_req", {31'd0, m_req}, 32'd1);
    chk("t1_c1_m_addr", m_addr, 32'h10);
    chk("t1_c1_m_we", {31'd0, m_we}, 32'd0);
    chk("t1_c1_m_be", {28'd0, m_be}, 32'hF);
    chk("t1_c1_stall_if", {31'd0, stall_if}, 32'd1);
    tick();
    #1;
    chk("t1_c2_if_done", {31'd0, if_done}, 32'd1);
    chk("t1_c2_if_rdata", if_rdata, 32'h0050_0093);
    chk("t1_c2_bus_err", {31'd0, bus_err}, 32'd0);
    chk("t1_c2_stall_if", {31'd0, stall_if}, 32'd0);
    chk("t1_c2_m_req", {31'd0, m_req}, 32'd0);
    tick();
    if_req = 1'b0; #1;
    chk("t1_c3_if_done", {31'd0, if_done}, 32'd0);
    tick();
    #1;
    chk("t1_c4_no_done", {30'd0, if_done, mem_done}, 32'd0);
    chk("t1_c4_m_req", {31'd0, m_req}, 32'd0);
    chk("t1_c4_rdata_hold", if_rdata, 32'h0050_0093);
    m_ready = 1'b0; m_rdata = 32'd0;

    // 2: simultaneous requests, MEM store first then IF
    tick();
    if_req = 1'b1; if_addr = 32'h20;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_be = 4'h3;
    #1;
    tick();
    m_ready = 1'b1; #1;
    chk("t2_c1_m_we", {31'd0, m_we}, 32'd1);
    chk("t2_c1_m_addr", m_addr, 32'h100);
    chk("t2_c1_m_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("t2_c1_m_be", {28'd0, m_be}, 32'h3);
    tick();
    m_ready = 1'b0; #1;
    chk("t2_c2_mem_done", {31'd0, mem_done}, 32'd1);
    chk("t2_c2_stall_mem", {31'd0, stall_mem}, 32'd0);
    chk("t2_c2_stall_if", {31'd0, stall_if}, 32'd1);
    tick();
    mem_req = 1'b0; mem_we = 1'b0; #1;
    chk("t2_c3_m_req", {31'd0, m_req}, 32'd0);
    tick();
    m_ready = 1'b1; m_rdata = 32'h1234_5678; #1;
    chk("t2_c4_m_addr", m_addr, 32'h20);
    chk("t2_c4_m_be", {28'd0, m_be}, 32'hF);
    tick();
    m_ready = 1'b0; #1;
    chk("t2_c5_if_done", {31'd0, if_done}, 32'd1);
    chk("t2_c5_if_rdata", if_rdata, 32'h1234_5678);
    tick();
    if_req = 1'b0;

    // 3: load with three wait states
    tick();
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_wdata = 32'd0; mem_be = 4'hF; #1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c == 4) begin
        m_ready = 1'b1; m_rdata = 32'hCAFE_F00D;
      end
      #1;
      chk($sformatf("t3_c%0d_m_req", c), {31'd0, m_req}, 32'd1);
      chk($sformatf("t3_c%0d_m_addr", c), m_addr, 32'h200);
      chk($sformatf("t3_c%0d_m_cmd", c), {27'd0, m_we, m_be}, 32'h0F);
      chk($sformatf("t3_c%0d_no_done", c), {31'd0, mem_done}, 32'd0);
    end
    tick();
    m_ready = 1'b0; #1;
    chk("t3_c5_mem_done", {31'd0, mem_done}, 32'd1);
    chk("t3_c5_mem_rdata", mem_rdata, 32'hCAFE_F00D);
    tick();
    mem_req = 1'b0;

    // 4: starvation bound, four MEM grants then IF, then MEM again
    tick();
    if_req = 1'b1; if_addr = 32'h40; mem_req = 1'b1; mem_addr = 32'h300;
    for (int g = 1; g <= 4; g++) begin
      tick();
      m_ready = 1'b1; m_rdata = 32'd0; #1;
      chk($sformatf("t4_g%0d_mem_addr", g), m_addr, 32'h300);
      tick();
      m_ready = 1'b0; #1;
      chk($sformatf("t4_g%0d_mem_done", g), {31'd0, mem_done}, 32'd1);
      tick();
    end
    chk("t4_streak_full", {28'd0, dut.streak_q}, 32'd4);
    tick();
    m_ready = 1'b1; m_rdata = 32'hA5A5_0001; #1;
    chk("t4_if_granted", m_addr, 32'h40);
    chk("t4_streak_clr", {28'd0, dut.streak_q}, 32'd0);
    tick();
    m_ready = 1'b0; #1;
    chk("t4_if_done", {31'd0, if_done}, 32'd1);
    tick();
    tick();
    m_ready = 1'b1; #1;
    chk("t4_mem_next", m_addr, 32'h300);
    tick();
    m_ready = 1'b0; #1;
    chk("t4_mem_next_done", {31'd0, mem_done}, 32'd1);
    tick();
    if_req = 1'b0; mem_req = 1'b0;

    // 5: timeout, then a ready arriving exactly on the timeout cycle
    tick();
    if_req = 1'b1; if_addr = 32'h80; #1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("t5_c%0d_m_req", c), {31'd0, m_req}, 32'd1);
    end
    tick();
    chk("t5_c9_if_done", {31'd0, if_done}, 32'd1);
    chk("t5_c9_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t5_c9_if_rdata", if_rdata, 32'd0);
    chk("t5_c9_m_req", {31'd0, m_req}, 32'd0);
    tick();
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 8) begin
        m_ready = 1'b1; m_rdata = 32'h55;
      end
    end
    tick();
    m_ready = 1'b0; #1;
    chk("t5_tie_if_done", {31'd0, if_done}, 32'd1);
    chk("t5_tie_bus_err", {31'd0, bus_err}, 32'd0);
    chk("t5_tie_if_rdata", if_rdata, 32'h55);
    tick();
    if_req = 1'b0;

    // 6: asynchronous reset in the middle of a wait-stated load
    tick();
    if_req = 1'b1; if_addr = 32'h90; mem_req = 1'b1; mem_addr = 32'h400; #1;
    tick();
    chk("t6_c1_m_addr", m_addr, 32'h400);
    chk("t6_c1_streak", {28'd0, dut.streak_q}, 32'd1);
    tick();
    #2;
    reset = 1'b1; #1;
    chk("t6_rst_m_req", {31'd0, m_req}, 32'd0);
    chk("t6_rst_idle", {30'd0, dut.state_q}, 32'd0);
    chk("t6_rst_streak", {28'd0, dut.streak_q}, 32'd0);
    if_req = 1'b0;
    tick();
    chk("t6_rst_no_done", {31'd0, mem_done}, 32'd0);
    reset = 1'b0; #1;
    chk("t6_rel_m_req", {31'd0, m_req}, 32'd0);
    tick();
    m_ready = 1'b1; m_rdata = 32'h77; #1;
    chk("t6_fresh_m_req", {31'd0, m_req}, 32'd1);
    chk("t6_fresh_m_addr", m_addr, 32'h400);
    tick();
    m_ready = 1'b0; #1;
    chk("t6_fresh_done", {31'd0, mem_done}, 32'd1);
    chk("t6_fresh_rdata", mem_rdata, 32'h77);
    tick();
    mem_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
